// File: rtl/axi_win_pkg.sv
// rtl/axi_win_pkg.sv - shared types and constants for the AXI address-window bridge
package axi_win_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Widest AXI ID carried in a route entry; narrower IDs are zero-extended.
  localparam int ROUTE_ID_W = 16;

  typedef struct packed {
    logic                  hit;
    logic [ROUTE_ID_W-1:0] id;
  } route_t;

  typedef enum logic {IDLE, ERR} rd_state_e;

endpackage

// File: rtl/axi_win_route_fifo.sv
// rtl/axi_win_route_fifo.sv - sync FIFO of write routes (hit/miss + id) in AW order
module axi_win_route_fifo
  import axi_win_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   push,
  input  route_t wr_data,
  input  logic   pop,
  output route_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  route_t        mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[PW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);

endmodule

// File: rtl/axi_mem_window.sv
// rtl/axi_mem_window.sv - AXI4 window remap bridge answering out-of-window bursts with DECERR
// Optional AXI_WIN_REG_SLICE_EN: 2-entry skid buffer registers m_aw/m_ar.
module axi_mem_window
  import axi_win_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter int                ID_W     = 6,
  parameter logic [ADDR_W-1:0] IN_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 32'h1000_0000,
  parameter int                WIN_BITS = 28,
  parameter int                MAX_OUT  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  logic [ADDR_W-1:0]   s_aw_addr,
  input  logic [ID_W-1:0]     s_aw_id,
  input  logic [7:0]          s_aw_len,
  input  logic [2:0]          s_aw_size,
  input  logic [1:0]          s_aw_burst,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [DATA_W-1:0]   s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb,
  input  logic                s_w_last,
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output logic [ID_W-1:0]     s_b_id,
  output logic [1:0]          s_b_resp,
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  input  logic [ADDR_W-1:0]   s_ar_addr,
  input  logic [ID_W-1:0]     s_ar_id,
  input  logic [7:0]          s_ar_len,
  input  logic [2:0]          s_ar_size,
  input  logic [1:0]          s_ar_burst,
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output logic [ID_W-1:0]     s_r_id,
  output logic [DATA_W-1:0]   s_r_data,
  output logic [1:0]          s_r_resp,
  output logic                s_r_last,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [ID_W-1:0]     m_aw_id,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W-1:0]     m_b_id,
  input  logic [1:0]          m_b_resp,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [ID_W-1:0]     m_ar_id,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [ID_W-1:0]     m_r_id,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last
);

  localparam logic [ADDR_W-1:0] WIN_MASK = ~({ADDR_W{1'b1}} << WIN_BITS);
  localparam int                CNT_W    = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUT);
  localparam int                AX_W     = ADDR_W + ID_W + 13;

  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    return (a & ~WIN_MASK) == IN_BASE;
  endfunction

  logic             live;
  logic             aw_hit, aw_cond, aw_fire, aw_slot, last_wroute, w_done, b_fire;
  logic             rf_full, rf_empty, rf_pop, head_hit, miss_head;
  logic [CNT_W-1:0] wr_out, rd_out;
  route_t           rf_in, rf_head;
  logic             ar_hit, ar_cond, ar_fire, ar_slot, rlast_fire;
  rd_state_e        rd_state, rd_next;
  logic [7:0]       err_len, err_cnt;
  logic [ID_W-1:0]  err_id;
  logic [AX_W-1:0]  aw_in, aw_out, ar_in, ar_out;

  // Holds every valid/ready output low until the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  assign aw_hit     = in_win(s_aw_addr);
  assign aw_cond    = live && (wr_out < MAX_CNT) && !rf_full &&
                      (wr_out == '0 || aw_hit == last_wroute);
  assign s_aw_ready = aw_cond && (aw_hit ? aw_slot : 1'b1);
  assign aw_fire    = s_aw_valid && s_aw_ready;
  assign aw_in      = {OUT_BASE | (s_aw_addr & WIN_MASK), s_aw_id, s_aw_len, s_aw_size, s_aw_burst};
  assign {m_aw_addr, m_aw_id, m_aw_len, m_aw_size, m_aw_burst} = aw_out;

  always_comb begin
    rf_in     = '0;
    rf_in.hit = aw_hit;
    rf_in.id  = ROUTE_ID_W'(s_aw_id);
  end

  axi_win_route_fifo #(.DEPTH(MAX_OUT)) u_route_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (aw_fire),
    .wr_data (rf_in),
    .pop     (rf_pop),
    .rd_data (rf_head),
    .full    (rf_full),
    .empty   (rf_empty)
  );

  assign head_hit  = !rf_empty && rf_head.hit;
  assign miss_head = !rf_empty && !rf_head.hit;
  assign m_w_valid = s_w_valid && head_hit;
  assign m_w_data  = s_w_data;
  assign m_w_strb  = s_w_strb;
  assign m_w_last  = s_w_last;
  assign s_w_ready = head_hit ? m_w_ready : (miss_head && !w_done);
  assign s_b_valid = miss_head ? w_done : (live && m_b_valid);
  assign s_b_id    = miss_head ? ID_W'(rf_head.id) : m_b_id;
  assign s_b_resp  = miss_head ? RESP_DECERR : m_b_resp;
  assign m_b_ready = live && !miss_head && s_b_ready;
  assign b_fire    = s_b_valid && s_b_ready;
  assign rf_pop    = (head_hit && s_w_valid && m_w_ready && s_w_last) || (miss_head && b_fire);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_out      <= '0;
      last_wroute <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      wr_out <= wr_out + CNT_W'(aw_fire) - CNT_W'(b_fire);
      if (aw_fire) last_wroute <= aw_hit;
      if (miss_head && b_fire)
        w_done <= 1'b0;
      else if (miss_head && s_w_valid && s_w_ready && s_w_last)
        w_done <= 1'b1;
    end
  end

  assign ar_hit     = in_win(s_ar_addr);
  assign ar_cond    = live && (rd_state == IDLE) &&
                      (ar_hit ? (rd_out < MAX_CNT) : (rd_out == '0));
  assign s_ar_ready = ar_cond && (ar_hit ? ar_slot : 1'b1);
  assign ar_fire    = s_ar_valid && s_ar_ready;
  assign rlast_fire = m_r_valid && m_r_ready && m_r_last;
  assign ar_in      = {OUT_BASE | (s_ar_addr & WIN_MASK), s_ar_id, s_ar_len, s_ar_size, s_ar_burst};
  assign {m_ar_addr, m_ar_id, m_ar_len, m_ar_size, m_ar_burst} = ar_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_state <= IDLE;
    else          rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      IDLE:    if (ar_fire && !ar_hit) rd_next = ERR;
      ERR:     if (s_r_ready && err_cnt == err_len) rd_next = IDLE;
      default: rd_next = IDLE;
    endcase
  end

  always_comb begin
    s_r_valid = live && m_r_valid;
    s_r_id    = m_r_id;
    s_r_data  = m_r_data;
    s_r_resp  = m_r_resp;
    s_r_last  = m_r_last;
    m_r_ready = live && s_r_ready;
    if (rd_state == ERR) begin
      s_r_valid = 1'b1;
      s_r_id    = err_id;
      s_r_data  = '0;
      s_r_resp  = RESP_DECERR;
      s_r_last  = (err_cnt == err_len);
      m_r_ready = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_out  <= '0;
      err_id  <= '0;
      err_len <= '0;
      err_cnt <= '0;
    end else begin
      rd_out <= rd_out + CNT_W'(ar_fire && ar_hit) - CNT_W'(rlast_fire);
      if (ar_fire && !ar_hit) begin
        err_id  <= s_ar_id;
        err_len <= s_ar_len;
        err_cnt <= '0;
      end else if (rd_state == ERR && s_r_ready) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

`ifdef AXI_WIN_REG_SLICE_EN
  logic            aw_out_v, aw_skid_v, ar_out_v, ar_skid_v, aw_push, ar_push;
  logic [AX_W-1:0] aw_skid, ar_skid;

  assign aw_push    = aw_fire && aw_hit;
  assign ar_push    = ar_fire && ar_hit;
  assign aw_slot    = !aw_skid_v;
  assign ar_slot    = !ar_skid_v;
  assign m_aw_valid = aw_out_v;
  assign m_ar_valid = ar_out_v;

  // Skid entry catches a request accepted in the cycle the output stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aw_out_v  <= 1'b0;
      aw_skid_v <= 1'b0;
      aw_out    <= '0;
      aw_skid   <= '0;
    end else if (!aw_skid_v) begin
      if (!aw_out_v || m_aw_ready) begin
        aw_out_v <= aw_push;
        if (aw_push) aw_out <= aw_in;
      end else if (aw_push) begin
        aw_skid_v <= 1'b1;
        aw_skid   <= aw_in;
      end
    end else if (m_aw_ready) begin
      aw_out    <= aw_skid;
      aw_skid_v <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ar_out_v  <= 1'b0;
      ar_skid_v <= 1'b0;
      ar_out    <= '0;
      ar_skid   <= '0;
    end else if (!ar_skid_v) begin
      if (!ar_out_v || m_ar_ready) begin
        ar_out_v <= ar_push;
        if (ar_push) ar_out <= ar_in;
      end else if (ar_push) begin
        ar_skid_v <= 1'b1;
        ar_skid   <= ar_in;
      end
    end else if (m_ar_ready) begin
      ar_out    <= ar_skid;
      ar_skid_v <= 1'b0;
    end
  end
`else
  assign aw_slot    = m_aw_ready;
  assign ar_slot    = m_ar_ready;
  assign m_aw_valid = s_aw_valid && aw_cond && aw_hit;
  assign m_ar_valid = s_ar_valid && ar_cond && ar_hit;
  assign aw_out     = aw_in;
  assign ar_out     = ar_in;
`endif

endmodule

// File: tb/tb_axi_mem_window.sv
// tb/tb_axi_mem_window.sv - directed self-checking bench for axi_mem_window
module tb_axi_mem_window;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        s_aw_valid, s_aw_ready;
  logic [31:0] s_aw_addr;
  logic [5:0]  s_aw_id;
  logic [7:0]  s_aw_len;
  logic [2:0]  s_aw_size;
  logic [1:0]  s_aw_burst;
  logic        s_w_valid, s_w_ready, s_w_last;
  logic [63:0] s_w_data;
  logic [7:0]  s_w_strb;
  logic        s_b_valid, s_b_ready;
  logic [5:0]  s_b_id;
  logic [1:0]  s_b_resp;
  logic        s_ar_valid, s_ar_ready;
  logic [31:0] s_ar_addr;
  logic [5:0]  s_ar_id;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic [1:0]  s_ar_burst;
  logic        s_r_valid, s_r_ready, s_r_last;
  logic [5:0]  s_r_id;
  logic [63:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        m_aw_valid, m_aw_ready;
  logic [31:0] m_aw_addr;
  logic [5:0]  m_aw_id;
  logic [7:0]  m_aw_len;
  logic [2:0]  m_aw_size;
  logic [1:0]  m_aw_burst;
  logic        m_w_valid, m_w_ready, m_w_last;
  logic [63:0] m_w_data;
  logic [7:0]  m_w_strb;
  logic        m_b_valid, m_b_ready;
  logic [5:0]  m_b_id;
  logic [1:0]  m_b_resp;
  logic        m_ar_valid, m_ar_ready;
  logic [31:0] m_ar_addr;
  logic [5:0]  m_ar_id;
  logic [7:0]  m_ar_len;
  logic [2:0]  m_ar_size;
  logic [1:0]  m_ar_burst;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [5:0]  m_r_id;
  logic [63:0] m_r_data;
  logic [1:0]  m_r_resp;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  axi_mem_window dut (
    .clock(clock), .reset_n(reset_n),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    s_ar_valid = 1'b1; s_ar_addr = a; s_ar_id = id; s_ar_len = len;
    s_ar_size = 3'd3; s_ar_burst = 2'd1;
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    s_aw_valid = 1'b1; s_aw_addr = a; s_aw_id = id; s_aw_len = len;
    s_aw_size = 3'd3; s_aw_burst = 2'd1;
  endtask

  initial begin
    reset_n = 1'b0;
    s_aw_valid = 1'b1; s_aw_addr = '0; s_aw_id = '0; s_aw_len = '0; s_aw_size = '0; s_aw_burst = '0;
    s_w_valid = 1'b0; s_w_data = '0; s_w_strb = 8'hff; s_w_last = 1'b0;
    s_b_ready = 1'b0;
    s_ar_valid = 1'b1; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0;
    s_r_ready = 1'b0;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    m_b_valid = 1'b0; m_b_id = '0; m_b_resp = '0;
    m_r_valid = 1'b0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0;

    repeat (2) tick();
    check("rst_s_aw_ready", s_aw_ready, 0);
    check("rst_s_ar_ready", s_ar_ready, 0);
    check("rst_m_aw_valid", m_aw_valid, 0);
    check("rst_m_ar_valid", m_ar_valid, 0);
    check("rst_s_w_ready", s_w_ready, 0);
    check("rst_s_b_valid", s_b_valid, 0);
    check("rst_s_r_valid", s_r_valid, 0);
    s_aw_valid = 1'b0; s_ar_valid = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();

    // hit read, 8 passthrough beats
    drive_ar(32'h0000_1040, 6'd3, 8'd7);
    #1;
    check("hit_ar_valid", m_ar_valid, 1);
    check("hit_ar_addr", m_ar_addr, 64'h1000_1040);
    check("hit_ar_id", m_ar_id, 3);
    check("hit_ar_len", m_ar_len, 7);
    check("hit_ar_ready", s_ar_ready, 1);
    tick();
    s_ar_valid = 1'b0; s_r_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_r_valid = 1'b1; m_r_id = 6'd3; m_r_data = 64'hA000 + 64'(i); m_r_last = (i == 7);
      #1;
      check("hit_r_valid", s_r_valid, 1);
      check("hit_r_id", s_r_id, 3);
      check("hit_r_data", s_r_data, 64'hA000 + 64'(i));
      check("hit_r_last", s_r_last, (i == 7) ? 1 : 0);
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;

    // miss read answered locally
    drive_ar(32'h2000_0000, 6'd5, 8'd3);
    #1;
    check("miss_ar_m_valid", m_ar_valid, 0);
    check("miss_ar_ready", s_ar_ready, 1);
    tick();
    s_ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive_ar(32'h0000_0100, 6'd9, 8'd0);
      #1;
      check("miss_r_valid", s_r_valid, 1);
      check("miss_r_data", s_r_data, 0);
      check("miss_r_resp", s_r_resp, 3);
      check("miss_r_id", s_r_id, 5);
      check("miss_r_last", s_r_last, (i == 3) ? 1 : 0);
      if (i == 1) begin
        check("err_ar_blocked", s_ar_ready, 0);
        check("err_m_ar_valid", m_ar_valid, 0);
        s_ar_valid = 1'b0;
      end
      tick();
    end
    #1;
    check("miss_r_done", s_r_valid, 0);
    tick();

    // miss write: W discarded, one DECERR B
    drive_aw(32'h3000_0000, 6'd2, 8'd1);
    #1;
    check("mw_aw_ready", s_aw_ready, 1);
    check("mw_m_aw_valid", m_aw_valid, 0);
    tick();
    s_aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_w_valid = 1'b1; s_w_data = 64'hDEAD; s_w_last = (i == 1);
      #1;
      check("mw_w_ready", s_w_ready, 1);
      check("mw_m_w_valid", m_w_valid, 0);
      tick();
    end
    s_w_valid = 1'b0; s_w_last = 1'b0;
    #1;
    check("mw_b_valid", s_b_valid, 1);
    check("mw_b_id", s_b_id, 2);
    check("mw_b_resp", s_b_resp, 3);
    tick();
    s_b_ready = 1'b1;
    #1;
    check("mw_b_hold", s_b_valid, 1);
    tick();
    #1;
    check("mw_b_done", s_b_valid, 0);
    tick();

    // ordering: miss AW waits for the hit B
    drive_aw(32'h0000_2000, 6'd1, 8'd0);
    #1;
    check("ord_hit_aw_ready", s_aw_ready, 1);
    check("ord_m_aw_valid", m_aw_valid, 1);
    check("ord_m_aw_addr", m_aw_addr, 64'h1000_2000);
    tick();
    s_aw_valid = 1'b0;
    s_w_valid = 1'b1; s_w_data = 64'h1234; s_w_last = 1'b1;
    #1;
    check("ord_m_w_valid", m_w_valid, 1);
    check("ord_m_w_data", m_w_data, 64'h1234);
    check("ord_s_w_ready", s_w_ready, 1);
    tick();
    s_w_valid = 1'b0;
    drive_aw(32'h3000_0000, 6'd1, 8'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ord_miss_stall", s_aw_ready, 0);
      tick();
    end
    m_b_valid = 1'b1; m_b_id = 6'd1; m_b_resp = 2'b00;
    #1;
    check("ord_hit_b_valid", s_b_valid, 1);
    check("ord_hit_b_id", s_b_id, 1);
    check("ord_hit_b_resp", s_b_resp, 0);
    check("ord_still_stall", s_aw_ready, 0);
    tick();
    m_b_valid = 1'b0;
    #1;
    check("ord_miss_aw_ready", s_aw_ready, 1);
    check("ord_miss_m_aw", m_aw_valid, 0);
    tick();
    s_aw_valid = 1'b0;
    s_w_valid = 1'b1; s_w_last = 1'b1;
    #1;
    check("ord_miss_w_ready", s_w_ready, 1);
    check("ord_miss_m_w", m_w_valid, 0);
    tick();
    s_w_valid = 1'b0; s_w_last = 1'b0;
    #1;
    check("ord_dec_b_valid", s_b_valid, 1);
    check("ord_dec_b_resp", s_b_resp, 3);
    check("ord_dec_b_id", s_b_id, 1);
    tick();
    #1;
    check("ord_dec_b_done", s_b_valid, 0);
    tick();

    // outstanding read limit
    for (int i = 0; i < 4; i++) begin
      drive_ar(32'h100 * 32'(i), 6'(i), 8'd0);
      #1;
      check("lim_ar_ready", s_ar_ready, 1);
      tick();
    end
    drive_ar(32'h500, 6'd4, 8'd0);
    #1;
    check("lim_5th_blocked", s_ar_ready, 0);
    check("lim_5th_m_valid", m_ar_valid, 0);
    tick();
    m_r_valid = 1'b1; m_r_id = 6'd0; m_r_last = 1'b1;
    #1;
    check("lim_r_valid", s_r_valid, 1);
    check("lim_still_blocked", s_ar_ready, 0);
    tick();
    m_r_valid = 1'b0;
    #1;
    check("lim_reenabled", s_ar_ready, 1);
    tick();
    s_ar_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      m_r_valid = 1'b1; m_r_id = 6'(i); m_r_last = 1'b1;
      #1;
      check("lim_drain_id", s_r_id, 64'(i));
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;

    // reset in the middle of a DECERR read burst
    drive_ar(32'h2000_0000, 6'd6, 8'd3);
    #1;
    check("rst_err_ar_ready", s_ar_ready, 1);
    tick();
    s_ar_valid = 1'b0;
    #1;
    check("rst_err_beat1_last", s_r_last, 0);
    tick();
    #1;
    check("rst_err_beat2_valid", s_r_valid, 1);
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_err_drop", s_r_valid, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    drive_ar(32'h2000_0000, 6'd7, 8'd1);
    #1;
    check("rst_new_ar_ready", s_ar_ready, 1);
    tick();
    s_ar_valid = 1'b0;
    #1;
    check("rst_new_id", s_r_id, 7);
    check("rst_new_beat1_last", s_r_last, 0);
    tick();
    #1;
    check("rst_new_beat2_last", s_r_last, 1);
    tick();
    #1;
    check("rst_new_done", s_r_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
